// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Port indices are also the encoding of the owner output.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // Wide enough for a latency load of RD_LAT-1 with RD_LAT up to 7.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: on a tie the port that did not win last time is chosen.
// grant_idx is only meaningful while valid is high.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       grant_idx
);

    always_comb begin
        valid     = |req;
        grant_idx = req[1];
        if (req == 2'b11) begin
            grant_idx = ~last;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and access sequencer sharing the single-port data memory between the CPU and the loader.
// One access in flight at a time; fixed read latency handled by a down-counter.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | sample requests, latch the winner's access into mem_* regs
//   ACCESS | mem_en high for one cycle, memory samples address/data
//   WAIT   | read only: count down the remaining memory read latency
//   DONE   | one-cycle ack to the owner, rdata valid for reads
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner,
    output logic [1:0]        state
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    arb_state_t           state_q;
    logic                 last_q;
    logic                 we_q;
    logic [LAT_CNT_W-1:0] lat_cnt_q;

    logic [1:0]           req_vec;
    logic                 pick_valid;
    logic                 pick_idx;

    logic                 win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    assign req_vec = {ldr_req, cpu_req};
    assign state   = state_q;

    rr_pick2 u_pick (
        .req       (req_vec),
        .last      (last_q),
        .valid     (pick_valid),
        .grant_idx (pick_idx)
    );

    always_comb begin
        win_we    = cpu_we;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        if (pick_idx == PORT_LDR) begin
            win_we    = ldr_we;
            win_addr  = ldr_addr;
            win_wdata = ldr_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= PORT_LDR;
            we_q      <= 1'b0;
            lat_cnt_q <= '0;
            owner     <= PORT_CPU;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        we_q      <= win_we;
                        owner     <= pick_idx;
                        last_q    <= pick_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= win_we;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (we_q) begin
                        cpu_ack <= (owner == PORT_CPU);
                        ldr_ack <= (owner == PORT_LDR);
                        state_q <= DONE;
                    end else begin
                        lat_cnt_q <= LAT_LOAD;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
                    end else begin
                        // Terminal count: mem_rdata is valid in this cycle.
                        rdata   <= mem_rdata;
                        cpu_ack <= (owner == PORT_CPU);
                        ldr_ack <= (owner == PORT_LDR);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3.
// Drivers push expected acks into per-instance queues; negedge monitors pop and compare.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v       [2];
    logic       cpu_req_v   [2];
    logic       cpu_we_v    [2];
    logic [8:0] cpu_addr_v  [2];
    logic [8:0] cpu_wdata_v [2];
    logic       cpu_ack_v   [2];
    logic       ldr_req_v   [2];
    logic       ldr_we_v    [2];
    logic [8:0] ldr_addr_v  [2];
    logic [8:0] ldr_wdata_v [2];
    logic       ldr_ack_v   [2];
    logic [8:0] rdata_v     [2];
    logic       mem_en_v    [2];
    logic       mem_we_v    [2];
    logic [8:0] mem_addr_v  [2];
    logic [8:0] mem_wdata_v [2];
    logic       owner_v     [2];
    logic [1:0] state_v     [2];

    logic [8:0] mem0 [0:511];
    logic [8:0] mem1 [0:511];
    logic [8:0] rp0;
    logic [8:0] rp1 [3];

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cyc [4];
    int ack_n;
    int dummy_w;

    typedef struct {
        int         port;
        bit         chk;
        logic [8:0] data;
        string      name;
    } exp_t;

    exp_t sbq0 [$];
    exp_t sbq1 [$];

    mem_port_arbiter #(.DATA_W(9), .ADDR_W(9), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst_v[0]),
        .cpu_req(cpu_req_v[0]), .cpu_we(cpu_we_v[0]), .cpu_addr(cpu_addr_v[0]),
        .cpu_wdata(cpu_wdata_v[0]), .cpu_ack(cpu_ack_v[0]),
        .ldr_req(ldr_req_v[0]), .ldr_we(ldr_we_v[0]), .ldr_addr(ldr_addr_v[0]),
        .ldr_wdata(ldr_wdata_v[0]), .ldr_ack(ldr_ack_v[0]),
        .rdata(rdata_v[0]), .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]),
        .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]), .mem_rdata(rp0),
        .owner(owner_v[0]), .state(state_v[0])
    );

    mem_port_arbiter #(.DATA_W(9), .ADDR_W(9), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst_v[1]),
        .cpu_req(cpu_req_v[1]), .cpu_we(cpu_we_v[1]), .cpu_addr(cpu_addr_v[1]),
        .cpu_wdata(cpu_wdata_v[1]), .cpu_ack(cpu_ack_v[1]),
        .ldr_req(ldr_req_v[1]), .ldr_we(ldr_we_v[1]), .ldr_addr(ldr_addr_v[1]),
        .ldr_wdata(ldr_wdata_v[1]), .ldr_ack(ldr_ack_v[1]),
        .rdata(rdata_v[1]), .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]),
        .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]), .mem_rdata(rp1[2]),
        .owner(owner_v[1]), .state(state_v[1])
    );

    // Memory models: read data is only valid exactly RD_LAT edges after a read strobe.
    always @(posedge clk) begin
        if (mem_en_v[0] && mem_we_v[0]) mem0[mem_addr_v[0]] <= mem_wdata_v[0];
        rp0 <= (mem_en_v[0] && !mem_we_v[0]) ? mem0[mem_addr_v[0]] : 9'h1FF;
    end

    always @(posedge clk) begin
        if (mem_en_v[1] && mem_we_v[1]) mem1[mem_addr_v[1]] <= mem_wdata_v[1];
        rp1[0] <= (mem_en_v[1] && !mem_we_v[1]) ? mem1[mem_addr_v[1]] : 9'h1FF;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int port, input bit chk, input logic [8:0] data,
                        input string name);
        exp_t e;
        e.port = port; e.chk = chk; e.data = data; e.name = name;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    task automatic sb_pop(input int d);
        exp_t e;
        bit   empty;
        empty = (d == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0);
        if (empty) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack dut%0d: cpu_ack=%0b ldr_ack=%0b with nothing expected",
                     d, cpu_ack_v[d], ldr_ack_v[d]);
        end else begin
            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            check({e.name, " both_acks"}, 32'(cpu_ack_v[d] & ldr_ack_v[d]), 32'd0);
            check({e.name, " ack_port"}, 32'(ldr_ack_v[d]), 32'(e.port));
            if (e.chk) check({e.name, " rdata"}, 32'(rdata_v[d]), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (cpu_ack_v[0] || ldr_ack_v[0]) sb_pop(0);
        if (cpu_ack_v[1] || ldr_ack_v[1]) sb_pop(1);
    end

    task automatic drive_port(input int d, input int port, input logic req, input logic we,
                              input logic [8:0] addr, input logic [8:0] wdata);
        if (port == 0) begin
            cpu_req_v[d] = req; cpu_we_v[d] = we; cpu_addr_v[d] = addr; cpu_wdata_v[d] = wdata;
        end else begin
            ldr_req_v[d] = req; ldr_we_v[d] = we; ldr_addr_v[d] = addr; ldr_wdata_v[d] = wdata;
        end
    endtask

    // Single access from an idle arbiter; cycle 0 is the IDLE cycle that sees the request.
    task automatic access(input int d, input int port, input logic we, input logic [8:0] addr,
                          input logic [8:0] wdata, input int exp_lat, input bit chk,
                          input logic [8:0] exp_rd, input string name, output int waits);
        int         lat;
        int         en_cnt;
        logic       en_we;
        logic [8:0] en_addr;
        logic [8:0] en_wd;
        lat = -1; en_cnt = 0; waits = 0;
        en_we = 1'bx; en_addr = 'x; en_wd = 'x;
        push(d, port, chk, exp_rd, name);
        @(posedge clk); #1;
        drive_port(d, port, 1'b1, we, addr, wdata);
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_en_v[d]) begin
                en_cnt++;
                en_we = mem_we_v[d]; en_addr = mem_addr_v[d]; en_wd = mem_wdata_v[d];
            end
            if (state_v[d] == 2'd2) waits++;
            if ((port == 0) ? cpu_ack_v[d] : ldr_ack_v[d]) lat = c;
        end
        @(posedge clk); #1;
        drive_port(d, port, 1'b0, we, addr, wdata);
        check({name, " ack_cycle"}, 32'(lat), 32'(exp_lat));
        check({name, " mem_en_cycles"}, 32'(en_cnt), 32'd1);
        check({name, " mem_we"}, 32'(en_we), 32'(we));
        check({name, " mem_addr"}, 32'(en_addr), 32'(addr));
        if (we) check({name, " mem_wdata"}, 32'(en_wd), 32'(wdata));
        check({name, " owner"}, 32'(owner_v[d]), 32'(port));
    endtask

    // Two requesters; each asks ncpu/nldr times holding req, dropping it after its last ack.
    task automatic dual(input int d,
                        input logic cwe, input logic [8:0] caddr, input logic [8:0] cwd,
                        input int cstart,
                        input logic lwe, input logic [8:0] laddr, input logic [8:0] lwd,
                        input int lstart, input int ncpu, input int nldr);
        int cc, lc;
        bit dc, dl;
        cc = 0; lc = 0; dc = 0; dl = 0; ack_n = 0;
        for (int i = 0; i < 4; i++) ack_cyc[i] = -1;
        @(posedge clk);
        for (int c = 0; c < 60 && (cc < ncpu || lc < nldr); c++) begin
            #1;
            if (dc) begin cpu_req_v[d] = 1'b0; dc = 0; end
            if (dl) begin ldr_req_v[d] = 1'b0; dl = 0; end
            if (c == cstart && ncpu > 0) drive_port(d, 0, 1'b1, cwe, caddr, cwd);
            if (c == lstart && nldr > 0) drive_port(d, 1, 1'b1, lwe, laddr, lwd);
            @(negedge clk);
            if (cpu_ack_v[d]) begin
                cc++;
                if (ack_n < 4) ack_cyc[ack_n] = c;
                ack_n++;
                if (cc == ncpu) dc = 1;
            end
            if (ldr_ack_v[d]) begin
                lc++;
                if (ack_n < 4) ack_cyc[ack_n] = c;
                ack_n++;
                if (lc == nldr) dl = 1;
            end
            @(posedge clk);
        end
        #1;
        cpu_req_v[d] = 1'b0;
        ldr_req_v[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bit found;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;
            drive_port(d, 0, 1'b0, 1'b0, 9'h000, 9'h000);
            drive_port(d, 1, 1'b0, 1'b0, 9'h000, 9'h000);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d mem_en", d),    32'(mem_en_v[d]),    32'd0);
            check($sformatf("reset%0d mem_we", d),    32'(mem_we_v[d]),    32'd0);
            check($sformatf("reset%0d mem_addr", d),  32'(mem_addr_v[d]),  32'd0);
            check($sformatf("reset%0d mem_wdata", d), 32'(mem_wdata_v[d]), 32'd0);
            check($sformatf("reset%0d cpu_ack", d),   32'(cpu_ack_v[d]),   32'd0);
            check($sformatf("reset%0d ldr_ack", d),   32'(ldr_ack_v[d]),   32'd0);
            check($sformatf("reset%0d rdata", d),     32'(rdata_v[d]),     32'd0);
            check($sformatf("reset%0d owner", d),     32'(owner_v[d]),     32'd0);
            check($sformatf("reset%0d state", d),     32'(state_v[d]),     32'd0);
        end

        // RD_LAT=1 instance
        access(0, 0, 1'b1, 9'h005, 9'h1A3, 2, 1'b0, 9'h000, "cpu_wr_005", dummy_w);
        access(0, 1, 1'b1, 9'h005, 9'h0F0, 2, 1'b0, 9'h000, "ldr_wr_005", dummy_w);
        access(0, 1, 1'b0, 9'h005, 9'h000, 3, 1'b1, 9'h0F0, "ldr_rd_005", dummy_w);

        @(posedge clk); #1 rst_v[0] = 1'b1;
        @(posedge clk); #1 rst_v[0] = 1'b0;
        @(negedge clk);
        check("rst_again state", 32'(state_v[0]), 32'd0);
        check("rst_again rdata", 32'(rdata_v[0]), 32'd0);
        check("rst_again owner", 32'(owner_v[0]), 32'd0);

        // Tie straight after reset: CPU first, then strict alternation.
        push(0, 0, 1'b0, 9'h000, "tie_cpu1");
        push(0, 1, 1'b0, 9'h000, "tie_ldr1");
        push(0, 0, 1'b0, 9'h000, "tie_cpu2");
        push(0, 1, 1'b0, 9'h000, "tie_ldr2");
        dual(0, 1'b1, 9'h010, 9'h011, 0, 1'b1, 9'h011, 9'h022, 0, 2, 2);
        check("tie ack_count", 32'(ack_n), 32'd4);
        check("tie ack0_cycle", 32'(ack_cyc[0]), 32'd2);
        check("tie ack1_cycle", 32'(ack_cyc[1]), 32'd5);
        check("tie ack2_cycle", 32'(ack_cyc[2]), 32'd8);
        check("tie ack3_cycle", 32'(ack_cyc[3]), 32'd11);

        // LDR write raised during a CPU read; CPU rdata must survive the write.
        push(0, 0, 1'b1, 9'h0F0, "busy_cpu_rd");
        push(0, 1, 1'b1, 9'h0F0, "busy_ldr_wr");
        dual(0, 1'b0, 9'h005, 9'h000, 0, 1'b1, 9'h005, 9'h077, 1, 1, 1);
        check("busy ack_count", 32'(ack_n), 32'd2);
        check("busy cpu_ack_cycle", 32'(ack_cyc[0]), 32'd3);
        check("busy ldr_ack_cycle", 32'(ack_cyc[1]), 32'd6);
        access(0, 0, 1'b0, 9'h005, 9'h000, 3, 1'b1, 9'h077, "cpu_rd_005_after", dummy_w);

        // RD_LAT=3 instance
        access(1, 1, 1'b1, 9'h0A0, 9'h155, 2, 1'b0, 9'h000, "lat3_ldr_wr", dummy_w);
        access(1, 0, 1'b0, 9'h0A0, 9'h000, 5, 1'b1, 9'h155, "lat3_cpu_rd", dummy_w);
        check("lat3 wait_cycles", 32'(dummy_w), 32'd3);

        // Reset while waiting on a read: no ack, arbiter back in IDLE.
        @(posedge clk); #1;
        drive_port(1, 0, 1'b1, 1'b0, 9'h0A0, 9'h000);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (state_v[1] == 2'd2) found = 1;
        end
        check("rstwait reached_wait", 32'(found), 32'd1);
        @(posedge clk); #1 rst_v[1] = 1'b1;
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        cpu_req_v[1] = 1'b0;
        @(negedge clk);
        check("rstwait state", 32'(state_v[1]), 32'd0);
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            if (cpu_ack_v[1] || ldr_ack_v[1]) acks++;
            @(negedge clk);
        end
        check("rstwait no_ack", 32'(acks), 32'd0);
        access(1, 1, 1'b1, 9'h0A1, 9'h0AA, 2, 1'b0, 9'h000, "rstwait_ldr_wr", dummy_w);
        access(1, 0, 1'b0, 9'h0A1, 9'h000, 5, 1'b1, 9'h0AA, "rstwait_cpu_rd", dummy_w);

        repeat (3) @(negedge clk);
        check("sb0 drained", 32'(sbq0.size()), 32'd0);
        check("sb1 drained", 32'(sbq1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
